fetch_prefetch_unit: RTL

- Parametrised next-generation fetch stage for the pipelined RISC-V core.
- Issues in-order instruction-memory requests over a req/gnt/rvalid handshake with variable latency.
- Buffers returned instructions with their PC in a prefetch FIFO, and presents one instruction per cycle to Decode.
- Handles Execute-stage redirects (branch/jump) by flushing the FIFO and discarding wrong-path responses still in flight.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_fifo.sv | 75 +++++++
 rtl/fetch_prefetch_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and sizing helpers for the fetch/prefetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   // Native instruction/PC width of the core.
   localparam int unsigned FETCH_XLEN  = 32;

   // Byte stride between consecutive instructions.
   localparam int unsigned INSTR_BYTES = 4;

   // One prefetch buffer slot: the instruction and the PC it came from.
   typedef struct packed {
      logic [FETCH_XLEN-1:0] pc;
      logic [FETCH_XLEN-1:0] instr;
   } fetch_entry_t;

   // Width of a counter that must represent 0..depth inclusive.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous prefetch FIFO with flush. DEPTH must be a power
//               of two; the pointers carry one extra MSB so full and empty
//               are told apart without a separate counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter type         entry_t = fetch_entry_t
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic                         flush_i,
   input  entry_t                       wdata_i,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [cnt_width(DEPTH)-1:0]  count_o,
   output entry_t                       head_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = cnt_width(DEPTH);

   logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
   entry_t         mem_q [DEPTH];

   // Pointer advance; a flush empties the buffer and overrides push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
         if (pop_i)  rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
      end
   end

   // Pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Data storage; contents are only meaningful between the pointers, so no reset.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) begin
         mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
      end
   end

   assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign count_o = CNT_W'(wr_ptr_q - rd_ptr_q);

   underflow_a: assert property (@(posedge clk) disable iff (rst)
      !(pop_i && empty_o && !flush_i));

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_unit
// Description : Fetch stage. Issues in-order instruction-memory requests,
//               buffers responses with their PC and presents one instruction
//               per cycle to Decode. Redirects flush the buffer and discard
//               wrong-path responses still in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned      XLEN       = FETCH_XLEN,
   parameter logic [XLEN-1:0]  RESET_PC   = '0,
   parameter int unsigned      FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             redirect_i,
   input  logic [XLEN-1:0]  redirect_pc_i,
   input  logic             stall_i,
   output logic             instr_valid_o,
   output logic [XLEN-1:0]  instr_o,
   output logic [XLEN-1:0]  pc_o,
   output logic [XLEN-1:0]  pc_plus4_o,
   output logic             imem_req_o,
   output logic [XLEN-1:0]  imem_addr_o,
   input  logic             imem_gnt_i,
   input  logic             imem_rvalid_i,
   input  logic [XLEN-1:0]  imem_rdata_i
);

   localparam int unsigned     CNT_W   = cnt_width(FIFO_DEPTH);
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } entry_t;

   logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_push;
   logic             fifo_pop;
   entry_t           fifo_head;
   entry_t           push_entry;

   logic [CNT_W:0]   credit_used;
   logic             issue;
   logic             resp_drop;

   // Every buffered entry and every in-flight request holds one slot.
   assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding_q};

   assign imem_req_o  = !rst && !redirect_i && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
   assign imem_addr_o = fetch_pc_q;
   assign issue       = imem_req_o && imem_gnt_i;

   assign resp_drop   = imem_rvalid_i && (drop_cnt_q != '0);
   assign fifo_push   = imem_rvalid_i && (drop_cnt_q == '0) && !redirect_i;
   assign push_entry  = '{pc: resp_pc_q, instr: imem_rdata_i};

   assign instr_valid_o = !fifo_empty && !redirect_i;
   assign fifo_pop      = instr_valid_o && !stall_i;

   // With the buffer empty, show the next expected PC and a zero instruction.
   assign instr_o    = fifo_empty ? '0 : fifo_head.instr;
   assign pc_o       = fifo_empty ? resp_pc_q : fifo_head.pc;
   assign pc_plus4_o = pc_o + PC_STEP;

   // Request PC and response PC tracking; a redirect retargets both.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      if (redirect_i) begin
         fetch_pc_d = redirect_pc_i;
         resp_pc_d  = redirect_pc_i;
      end else begin
         if (issue)     fetch_pc_d = fetch_pc_q + PC_STEP;
         if (fifo_push) resp_pc_d  = resp_pc_q + PC_STEP;
      end
   end

   // In-flight and to-be-discarded response counters.
   always_comb begin
      outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(imem_rvalid_i);
      drop_cnt_d    = drop_cnt_q;
      if (redirect_i) begin
         // The in-flight count already covers earlier pending drops, so after
         // a redirect everything still outstanding is wrong-path.
         if (imem_rvalid_i && (outstanding_q == '0)) begin
            drop_cnt_d = '0;
         end else begin
            drop_cnt_d = outstanding_q - CNT_W'(imem_rvalid_i);
         end
      end else if (resp_drop) begin
         drop_cnt_d = drop_cnt_q - CNT_W'(1);
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   fetch_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .flush_i (redirect_i),
      .wdata_i (push_entry),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count),
      .head_o  (fifo_head)
   );

   push_overflow_a: assert property (@(posedge clk) disable iff (rst)
      !(fifo_push && fifo_full && !fifo_pop));

   credit_a: assert property (@(posedge clk) disable iff (rst)
      credit_used <= (CNT_W+1)'(FIFO_DEPTH));

endmodule
`default_nettype wire
